// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) memory arbiter: round-robin on contention,
// one transaction in flight, response routed to its owner, watchdog error on silence.
//
// state | meaning
// IDLE  | no transaction; arbitrate ifu/lsu requests
// REQ   | payload presented on mem port, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_resp_valid or watchdog expiry
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_valid,
  input  logic [AW-1:0]     ifu_addr,
  input  logic              ifu_wen,
  input  logic [DW-1:0]     ifu_wdata,
  input  logic [DW/8-1:0]   ifu_wmask,
  output logic              ifu_ready,
  output logic              ifu_rvalid,
  output logic [DW-1:0]     ifu_rdata,
  output logic              ifu_err,
  input  logic              lsu_valid,
  input  logic [AW-1:0]     lsu_addr,
  input  logic              lsu_wen,
  input  logic [DW-1:0]     lsu_wdata,
  input  logic [DW/8-1:0]   lsu_wmask,
  output logic              lsu_ready,
  output logic              lsu_rvalid,
  output logic [DW-1:0]     lsu_rdata,
  output logic              lsu_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_wen,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DW-1:0]     mem_resp_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = LSU owns the transaction
  logic              rr_q, rr_d;         // last winner, 1 = LSU
  logic [15:0]       cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wmask_q, wmask_d;

  logic              grant_lsu;
  logic              acc;
  logic              resp;
  logic              resp_err;
  logic [DW-1:0]     resp_data;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    grant_lsu = 1'b0;
    acc       = 1'b0;
    resp      = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    unique case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        grant_lsu = lsu_valid && !(ifu_valid && rr_q);
        if (ifu_valid || lsu_valid) begin
          owner_d = grant_lsu;
          rr_d    = grant_lsu;
          addr_d  = grant_lsu ? lsu_addr  : ifu_addr;
          wen_d   = grant_lsu ? lsu_wen   : ifu_wen;
          wdata_d = grant_lsu ? lsu_wdata : ifu_wdata;
          wmask_d = grant_lsu ? lsu_wmask : ifu_wmask;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          acc     = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A real response beats a watchdog expiry in the same cycle.
        if (mem_resp_valid) begin
          resp      = 1'b1;
          resp_data = mem_resp_rdata;
          state_d   = IDLE;
        end else if (cnt_q == TO_VAL) begin
          resp     = 1'b1;
          resp_err = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  assign ifu_ready  = acc & ~owner_q;
  assign lsu_ready  = acc & owner_q;
  assign ifu_rvalid = resp & ~owner_q;
  assign lsu_rvalid = resp & owner_q;
  assign ifu_rdata  = (resp & ~owner_q) ? resp_data : '0;
  assign lsu_rdata  = (resp & owner_q) ? resp_data : '0;
  assign ifu_err    = resp_err & ~owner_q;
  assign lsu_err    = resp_err & owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers, a randomized memory model,
// transaction-level arbitration prediction and a negedge monitor.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct packed {
    logic        who;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct {
    logic        who;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ifu_valid = 1'b0, lsu_valid = 1'b0;
  logic [31:0] ifu_addr = '0, lsu_addr = '0, ifu_wdata = '0, lsu_wdata = '0;
  logic ifu_wen = 1'b0, lsu_wen = 1'b0;
  logic [3:0] ifu_wmask = '0, lsu_wmask = '0;
  logic ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, ifu_err, lsu_err;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic mem_req_valid, mem_wen;
  logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wmask;
  logic [31:0] mem_resp_rdata = '0;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_wen(ifu_wen),
    .ifu_wdata(ifu_wdata), .ifu_wmask(ifu_wmask), .ifu_ready(ifu_ready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_ready(lsu_ready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  wire [139:0] all_outs = {ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata,
                           ifu_err, lsu_err, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask};

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit mon_en = 0, pending = 0, held = 0, force_ready = 0, spur_en = 0, late_req = 0;
  bit use_force_rd = 0, last_lsu = 0;
  int widx = 0, lat = 0, req_cycles = 0, last_req_cycles = 0, hold_req = 0;
  int force_lat = -1, late_due_cyc = -1;
  logic [31:0] rd_val = '0, force_rd = '0;
  logic [68:0] pay = '0, held_pay = '0;
  logic [1:0]  exp_rdy = 2'b00;
  req_t exp_mem[$];
  rsp_t exp_rsp[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model drive phase: ready, response strobe and data.
  initial forever begin
    @(posedge clk);
    #1;
    if (req_cycles < hold_req) mem_req_ready = 1'b0;
    else if (force_ready) mem_req_ready = 1'b1;
    else mem_req_ready = (($urandom % 3) != 0);
    if (pending) begin
      mem_resp_valid = (widx == lat);
      mem_resp_rdata = rd_val;
    end else begin
      mem_resp_valid = (cyc == late_due_cyc) || (spur_en && (($urandom % 6) == 0));
      mem_resp_rdata = $urandom;
    end
  end

  // Monitor and memory model sample phase.
  initial forever begin
    @(negedge clk);
    if (!rst_n || !mon_en) begin
      pending = 0;
      held = 0;
      req_cycles = 0;
      exp_mem.delete();
      exp_rsp.delete();
    end else begin
      exp_rdy = 2'b00;
      if (!ifu_rvalid) chk("ifu_quiet", 160'({ifu_rdata, ifu_err}), 160'(0));
      if (!lsu_rvalid) chk("lsu_quiet", 160'({lsu_rdata, lsu_err}), 160'(0));
      if (ifu_rvalid || lsu_rvalid) begin
        if (exp_rsp.size() == 0) begin
          flag("unexpected_rvalid", $sformatf("got ifu/lsu rvalid %b%b, expected none", ifu_rvalid, lsu_rvalid));
        end else begin
          rsp_t rs;
          rs = exp_rsp.pop_front();
          chk("rvalid_owner", 160'({ifu_rvalid, lsu_rvalid}), 160'(rs.who ? 2'b01 : 2'b10));
          chk("rdata", 160'(rs.who ? lsu_rdata : ifu_rdata), 160'(rs.rdata));
          chk("err", 160'(rs.who ? lsu_err : ifu_err), 160'(rs.err));
          chk("rvalid_cycle", 160'(cyc), 160'(rs.due));
        end
      end else if (exp_rsp.size() > 0 && cyc > exp_rsp[0].due) begin
        flag("rvalid_missing", $sformatf("got no rvalid by cycle %0d, expected at cycle %0d", cyc, exp_rsp[0].due));
        void'(exp_rsp.pop_front());
      end
      if (pending) begin
        chk("req_valid_in_wait", 160'(mem_req_valid), 160'(0));
        if (widx == lat || widx == TO) begin
          pending = 0;
          if (lat > TO && late_req) late_due_cyc = cyc + 1;
        end else begin
          widx++;
        end
      end else if (mem_req_valid) begin
        pay = {mem_addr, mem_wen, mem_wdata, mem_wmask};
        if (held) chk("payload_stable", 160'(pay), 160'(held_pay));
        held = 1;
        held_pay = pay;
        req_cycles++;
        if (mem_req_ready) begin
          held = 0;
          last_req_cycles = req_cycles;
          req_cycles = 0;
          if (exp_mem.size() == 0) begin
            flag("unexpected_grant", $sformatf("got request addr 0x%0h, expected none", mem_addr));
          end else begin
            req_t e;
            rsp_t r;
            e = exp_mem.pop_front();
            chk("mem_payload", 160'(pay), 160'({e.addr, e.wen, e.wdata, e.wmask}));
            exp_rdy = e.who ? 2'b01 : 2'b10;
            if (force_lat >= 0) lat = force_lat;
            else if (($urandom % 10) < 7) lat = $urandom_range(0, 3);
            else if (($urandom % 2) == 0) lat = TO;
            else lat = TO + 1 + $urandom_range(0, 2);
            rd_val = use_force_rd ? force_rd : $urandom;
            r.who = e.who;
            r.err = (lat > TO);
            r.rdata = (lat > TO) ? 32'h0 : rd_val;
            r.due = cyc + 1 + ((lat > TO) ? TO : lat);
            exp_rsp.push_back(r);
            pending = 1;
            widx = 0;
          end
        end
      end
      chk("ready_pulse", 160'({ifu_ready, lsu_ready}), 160'(exp_rdy));
    end
  end

  function automatic req_t rand_req(input logic who);
    req_t r;
    r.who = who;
    r.addr = $urandom;
    r.wen = 1'($urandom % 2);
    r.wdata = $urandom;
    r.wmask = 4'($urandom % 16);
    return r;
  endfunction

  task automatic issue(input logic who, input req_t r, output int st, output int rc);
    int t;
    @(posedge clk);
    #1;
    if (who) begin
      lsu_valid = 1'b1; lsu_addr = r.addr; lsu_wen = r.wen; lsu_wdata = r.wdata; lsu_wmask = r.wmask;
    end else begin
      ifu_valid = 1'b1; ifu_addr = r.addr; ifu_wen = r.wen; ifu_wdata = r.wdata; ifu_wmask = r.wmask;
    end
    st = cyc;
    rc = -1;
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      if ((who ? lsu_ready : ifu_ready) === 1'b1) begin
        rc = cyc;
        break;
      end
      t++;
    end
    if (rc < 0) flag(who ? "lsu_ready_timeout" : "ifu_ready_timeout", "got no ready in 200 cycles, expected one pulse");
    @(posedge clk);
    #1;
    if (who) lsu_valid = 1'b0;
    else ifu_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_mem.size() != 0 || exp_rsp.size() != 0 || pending) && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (t >= 400) flag("drain_timeout", $sformatf("got %0d requests/%0d responses outstanding, expected 0", exp_mem.size(), exp_rsp.size()));
    @(posedge clk);
  endtask

  // Reference arbitration: a lone requester wins; on a tie the one that did not
  // win last goes first and the other follows, leaving the last winner unchanged.
  task automatic round(input bit ui, input bit ul, input req_t ri, input req_t rl,
                       output int is, output int ir, output int ls, output int lr);
    is = -1; ir = -1; ls = -1; lr = -1;
    if (ui && ul) begin
      if (last_lsu) begin exp_mem.push_back(ri); exp_mem.push_back(rl); end
      else begin exp_mem.push_back(rl); exp_mem.push_back(ri); end
    end else if (ui) begin
      exp_mem.push_back(ri);
      last_lsu = 0;
    end else if (ul) begin
      exp_mem.push_back(rl);
      last_lsu = 1;
    end
    fork
      if (ui) issue(1'b0, ri, is, ir);
      if (ul) issue(1'b1, rl, ls, lr);
    join
    drain();
  endtask

  initial begin
    int s0, r0, s1, r1, k;
    req_t ri, rl;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", 160'(all_outs), 160'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1;

    // Zero-wait IFU read.
    force_ready = 1; force_lat = 0; use_force_rd = 1; force_rd = 32'h00100073;
    ri = '{who: 1'b0, addr: 32'h80000000, wen: 1'b0, wdata: 32'h0, wmask: 4'h0};
    round(1, 0, ri, ri, s0, r0, s1, r1);
    chk("ifu_ready_latency", 160'(r0), 160'(s0 + 1));

    // LSU byte store.
    use_force_rd = 0; force_lat = 2;
    rl = '{who: 1'b1, addr: 32'h80001003, wen: 1'b1, wdata: 32'h000000AB, wmask: 4'b0001};
    round(0, 1, rl, rl, s0, r0, s1, r1);
    chk("lsu_ready_latency", 160'(r1), 160'(s1 + 1));

    // Memory holds off acceptance for 5 cycles.
    hold_req = 5; force_lat = 1;
    round(1, 0, rand_req(1'b0), rl, s0, r0, s1, r1);
    chk("held_req_cycles", 160'(last_req_cycles), 160'(6));
    chk("held_ready_cycle", 160'(r0), 160'(s0 + 6));
    hold_req = 0;

    // Silent memory: watchdog error, then a stray late response.
    force_lat = 99; late_req = 1;
    round(0, 1, ri, rand_req(1'b1), s0, r0, s1, r1);
    late_req = 0;
    // Response lands exactly on the watchdog cycle.
    force_lat = TO;
    round(1, 0, rand_req(1'b0), rl, s0, r0, s1, r1);

    force_ready = 0; force_lat = -1; spur_en = 1;
    repeat (60) begin
      k = $urandom_range(1, 3);
      round(k[0], k[1], rand_req(1'b0), rand_req(1'b1), s0, r0, s1, r1);
    end

    // Reset while waiting for a response.
    spur_en = 0; force_ready = 1; force_lat = 99;
    ri = rand_req(1'b0);
    exp_mem.push_back(ri);
    issue(1'b0, ri, s0, r0);
    @(posedge clk);
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_wait_outputs", 160'(all_outs), 160'(0));
    last_lsu = 0; force_lat = -1; force_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1;
    round(1, 1, rand_req(1'b0), rand_req(1'b1), s0, r0, s1, r1);
    chk("post_reset_tie_lsu_first", 160'(r1 < r0), 160'(1));
    round(1, 1, rand_req(1'b0), rand_req(1'b1), s0, r0, s1, r1);
    round(1, 0, rand_req(1'b0), rl, s0, r0, s1, r1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "time limit");
  end
endmodule
